// File: rtl/aip_bus_arbiter.sv
// Round-robin arbiter sharing one AIP slave between NUM_REQ requesters; read/write complete in STROBE_CYC+3 cycles, start in STROBE_CYC+2.
// Backpressure: req_ready is granted only in IDLE (lock owner only while locked); losers hold req_valid and wait.
module aip_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 32,
    parameter int CONF_W     = 5,
    parameter int STROBE_CYC = 1
) (
    input  logic                        clk,
    input  logic                        rst_a,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [CONF_W*NUM_REQ-1:0]   req_config,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]          int_out,
    output logic [CONF_W-1:0]           aip_config,
    output logic [DATA_W-1:0]           aip_dataIn,
    output logic                        aip_read,
    output logic                        aip_write,
    output logic                        aip_start,
    input  logic [DATA_W-1:0]           aip_dataOut,
    input  logic                        aip_int
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   lock_owner;
    logic [IW-1:0]   start_owner;
    logic            locked;
    logic [1:0]      op_q;
    logic [3:0]      cnt;

    logic [1:0]        op_arr  [NUM_REQ];
    logic [CONF_W-1:0] cfg_arr [NUM_REQ];
    logic [DATA_W-1:0] dat_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]  = req_op[2*i +: 2];
        assign cfg_arr[i] = req_config[CONF_W*i +: CONF_W];
        assign dat_arr[i] = req_data[DATA_W*i +: DATA_W];
    end

    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;

    // Scan downward in offset so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (locked) begin
            gnt_vld = req_valid[lock_owner];
            gnt_idx = lock_owner;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                j = int'(ptr) + i;
                if (j >= NUM_REQ)
                    j = j - NUM_REQ;
                if (req_valid[IW'(j)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
        end
    end

    assign req_ready = (state == IDLE && gnt_vld && rst_a) ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            lock_owner  <= '0;
            start_owner <= '0;
            locked      <= 1'b0;
            op_q        <= 2'b00;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            int_out     <= '0;
            aip_config  <= '0;
            aip_dataIn  <= '0;
            aip_read    <= 1'b0;
            aip_write   <= 1'b0;
            aip_start   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            int_out   <= aip_int ? (NUM_REQ'(1) << start_owner) : '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        cur        <= gnt_idx;
                        op_q       <= op_arr[gnt_idx];
                        aip_config <= cfg_arr[gnt_idx];
                        aip_dataIn <= dat_arr[gnt_idx];
                        ptr        <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(gnt_idx + 1'b1);
                        locked     <= req_lock[gnt_idx];
                        lock_owner <= gnt_idx;
                        cnt        <= '0;
                        if (op_arr[gnt_idx][1]) begin
                            // start (and reserved op) skips the setup phase
                            start_owner <= gnt_idx;
                            aip_start   <= 1'b1;
                            state       <= STROBE;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    aip_read  <= (op_q == 2'b00);
                    aip_write <= (op_q == 2'b01);
                    state     <= STROBE;
                end
                STROBE: begin
                    if (cnt == 4'(STROBE_CYC - 1)) begin
                        aip_read  <= 1'b0;
                        aip_write <= 1'b0;
                        aip_start <= 1'b0;
                        if (op_q == 2'b00)
                            rsp_data <= aip_dataOut;
                        rsp_valid <= NUM_REQ'(1) << cur;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aip_bus_arbiter.sv
// Scoreboard bench for aip_bus_arbiter: directed commands push expected slave accesses and responses; negedge monitors pop and compare.
module tb_aip_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;

    logic        v     [2];
    logic [1:0]  op_a  [2];
    logic [4:0]  cfg_a [2];
    logic [31:0] dat_a [2];
    logic        lk_a  [2];

    logic [1:0]  req_valid, req_lock, req_ready, rsp_valid, int_out;
    logic [3:0]  req_op;
    logic [9:0]  req_config;
    logic [63:0] req_data;
    logic [31:0] rsp_data, aip_dataIn, dout1;
    logic [4:0]  aip_config;
    logic        aip_read, aip_write, aip_start, aip_int;

    assign req_valid  = {v[1], v[0]};
    assign req_op     = {op_a[1], op_a[0]};
    assign req_config = {cfg_a[1], cfg_a[0]};
    assign req_data   = {dat_a[1], dat_a[0]};
    assign req_lock   = {lk_a[1], lk_a[0]};

    aip_bus_arbiter #(.NUM_REQ(2), .DATA_W(32), .CONF_W(5), .STROBE_CYC(1)) dut (
        .clk(clk), .rst_a(rst_a),
        .req_valid(req_valid), .req_op(req_op), .req_config(req_config),
        .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .int_out(int_out),
        .aip_config(aip_config), .aip_dataIn(aip_dataIn),
        .aip_read(aip_read), .aip_write(aip_write), .aip_start(aip_start),
        .aip_dataOut(dout1), .aip_int(aip_int)
    );

    logic [1:0]  req_valid3, req_lock3, req_ready3, rsp_valid3, int_out3;
    logic [3:0]  req_op3;
    logic [9:0]  req_config3;
    logic [63:0] req_data3;
    logic [31:0] rsp_data3, aip_dataIn3, dout3;
    logic [4:0]  aip_config3;
    logic        aip_read3, aip_write3, aip_start3, aip_int3;

    aip_bus_arbiter #(.NUM_REQ(2), .DATA_W(32), .CONF_W(5), .STROBE_CYC(3)) dut3 (
        .clk(clk), .rst_a(rst_a),
        .req_valid(req_valid3), .req_op(req_op3), .req_config(req_config3),
        .req_data(req_data3), .req_lock(req_lock3), .req_ready(req_ready3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .int_out(int_out3),
        .aip_config(aip_config3), .aip_dataIn(aip_dataIn3),
        .aip_read(aip_read3), .aip_write(aip_write3), .aip_start(aip_start3),
        .aip_dataOut(dout3), .aip_int(aip_int3)
    );

    typedef struct {
        logic [2:0]  strb;
        logic [4:0]  cfg;
        logic [31:0] dat;
    } slv_t;

    typedef struct {
        int          req;
        logic [31:0] dat;
    } rsp_t;

    slv_t slv_q[$];
    rsp_t rsp_q[$];
    slv_t se;
    rsp_t re;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_rd;
    logic [2:0]  prev_strb;
    logic [2:0]  cur_strb;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Slave-side monitor: every new strobe must match the next expected access.
    always @(negedge clk) begin
        if (!rst_a) begin
            prev_strb = 3'b000;
        end else begin
            cur_strb = {aip_start, aip_write, aip_read};
            if (cur_strb != 3'b000)
                chk("strobe_onehot", 128'($onehot(cur_strb)), 128'd1);
            if (cur_strb != 3'b000 && prev_strb == 3'b000) begin
                if (slv_q.size() == 0) begin
                    chk("slave_unexpected", 128'(cur_strb), 128'd0);
                end else begin
                    se = slv_q.pop_front();
                    chk("slave_op", 128'(cur_strb), 128'(se.strb));
                    chk("slave_cfg", 128'(aip_config), 128'(se.cfg));
                    chk("slave_data", 128'(aip_dataIn), 128'(se.dat));
                end
            end
            prev_strb = cur_strb;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_a && rsp_valid != 2'b00) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
            end else begin
                re = rsp_q.pop_front();
                chk("rsp_owner", 128'(rsp_valid), 128'(2'b01 << re.req));
                chk("rsp_data", 128'(rsp_data), 128'(re.dat));
            end
        end
    end

    task automatic exp_op(input int r, input logic [1:0] op, input logic [4:0] cfg,
                          input logic [31:0] d, input logic [31:0] rd);
        slv_t s;
        rsp_t p;
        s.strb = (op == 2'b00) ? 3'b001 : (op == 2'b01) ? 3'b010 : 3'b100;
        s.cfg  = cfg;
        s.dat  = d;
        slv_q.push_back(s);
        if (op == 2'b00)
            last_rd = rd;
        p.req = r;
        p.dat = last_rd;
        rsp_q.push_back(p);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic drv(input int r, input logic [1:0] op, input logic [4:0] cfg,
                       input logic [31:0] d, input logic lk);
        int n;
        n = 0;
        op_a[r] = op; cfg_a[r] = cfg; dat_a[r] = d; lk_a[r] = lk; v[r] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 200);
        if (!req_ready[r])
            chk("accept_timeout", 128'(req_ready[r]), 128'd1);
        @(posedge clk);
        #1;
        v[r] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (rsp_q.size() != 0)
            chk("drain_timeout", 128'(rsp_q.size()), 128'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; op_a[i] = 2'b00; cfg_a[i] = 5'd0; dat_a[i] = 32'd0; lk_a[i] = 1'b0;
        end
        dout1 = 32'd0; aip_int = 1'b0; last_rd = 32'd0;
        req_valid3 = 2'b00; req_op3 = 4'd0; req_config3 = 10'd0; req_data3 = 64'd0;
        req_lock3 = 2'b00; dout3 = 32'd0; aip_int3 = 1'b0;

        // Reset state, with a pending request that must not see ready.
        v[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 128'({req_ready, rsp_valid, rsp_data, int_out, aip_config,
                                   aip_dataIn, aip_read, aip_write, aip_start}), 128'd0);
        chk("reset_outputs3", 128'({req_ready3, rsp_valid3, rsp_data3, int_out3, aip_config3,
                                    aip_dataIn3, aip_read3, aip_write3, aip_start3}), 128'd0);
        v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;

        // Single read, cycle-exact.
        dout1 = 32'h0000_1001;
        exp_op(0, 2'b00, 5'd31, 32'd0, 32'h0000_1001);
        drv(0, 2'b00, 5'd31, 32'd0, 1'b0);
        @(negedge clk);
        chk("rd_cfg_t1", 128'(aip_config), 128'd31);
        chk("rd_strobe_t1", 128'(aip_read), 128'd0);
        @(negedge clk);
        chk("rd_strobe_t2", 128'(aip_read), 128'd1);
        @(negedge clk);
        chk("rd_strobe_t3", 128'(aip_read), 128'd0);
        chk("rd_rsp_t3", 128'(rsp_valid), 128'(2'b01));
        @(posedge clk);
        #1;
        drain();

        // Start from R1 and interrupt routing.
        exp_op(1, 2'b10, 5'd3, 32'h55, 32'd0);
        drv(1, 2'b10, 5'd3, 32'h55, 1'b0);
        @(negedge clk);
        chk("start_t1", 128'(aip_start), 128'd1);
        @(negedge clk);
        chk("start_t2", 128'(aip_start), 128'd0);
        chk("start_rsp_t2", 128'(rsp_valid), 128'(2'b10));
        @(posedge clk);
        #1;
        repeat (7) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            aip_int = (k < 3);
            @(negedge clk);
            chk("int_out", 128'(int_out), (k >= 1 && k <= 3) ? 128'(2'b10) : 128'd0);
            @(posedge clk);
            #1;
        end
        drain();

        // Round-robin between two streaming writers.
        for (int i = 1; i <= 3; i++) begin
            exp_op(0, 2'b01, 5'd2, 32'hA000_0000 + i, 32'd0);
            exp_op(1, 2'b01, 5'd2, 32'hB000_0000 + i, 32'd0);
        end
        fork
            begin
                for (int i = 1; i <= 3; i++) drv(0, 2'b01, 5'd2, 32'hA000_0000 + i, 1'b0);
            end
            begin
                for (int i = 1; i <= 3; i++) drv(1, 2'b01, 5'd2, 32'hB000_0000 + i, 1'b0);
            end
        join
        drain();

        // Locked burst from R1, including an idle gap, while R0 keeps requesting.
        exp_op(1, 2'b01, 5'd1, 32'h10, 32'd0);
        for (int i = 1; i <= 4; i++) exp_op(1, 2'b01, 5'd0, 32'h10 + i, 32'd0);
        exp_op(0, 2'b01, 5'd2, 32'hA5, 32'd0);
        fork
            begin
                drv(1, 2'b01, 5'd1, 32'h10, 1'b1);
                drv(1, 2'b01, 5'd0, 32'h11, 1'b1);
                repeat (5) @(posedge clk);
                #1;
                drv(1, 2'b01, 5'd0, 32'h12, 1'b1);
                drv(1, 2'b01, 5'd0, 32'h13, 1'b1);
                drv(1, 2'b01, 5'd0, 32'h14, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                drv(0, 2'b01, 5'd2, 32'hA5, 1'b0);
            end
        join
        drain();

        // Asynchronous reset in the middle of a write strobe.
        exp_op(0, 2'b01, 5'd4, 32'hDEAD_0001, 32'd0);
        drv(0, 2'b01, 5'd4, 32'hDEAD_0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_active", 128'(aip_write), 128'd1);
        #2;
        rst_a = 1'b0;
        #1;
        chk("rst_async_drop", 128'(aip_write), 128'd0);
        chk("rst_mid_outputs", 128'({req_ready, rsp_valid, rsp_data, int_out, aip_config,
                                     aip_dataIn, aip_read, aip_write, aip_start}), 128'd0);
        rsp_q.delete();
        last_rd = 32'd0;
        v[1] = 1'b1;
        @(negedge clk);
        chk("rst_no_ready", 128'(req_ready), 128'd0);
        v[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        exp_op(0, 2'b01, 5'd2, 32'hC000_0001, 32'd0);
        exp_op(1, 2'b01, 5'd2, 32'hC000_0002, 32'd0);
        fork
            drv(0, 2'b01, 5'd2, 32'hC000_0001, 1'b0);
            drv(1, 2'b01, 5'd2, 32'hC000_0002, 1'b0);
        join
        drain();

        // STROBE_CYC=3 read: slave changes data every strobe cycle.
        begin
            logic [31:0] tbl [4];
            int n;
            tbl[0] = 32'h111; tbl[1] = 32'h222; tbl[2] = 32'h333; tbl[3] = 32'h444;
            n = 0;
            req_op3 = 4'd0; req_config3 = {5'd0, 5'd7}; req_valid3 = 2'b01;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready3[0] && n < 50);
            chk("s3_accept", 128'(req_ready3), 128'(2'b01));
            @(posedge clk);
            #1;
            req_valid3 = 2'b00;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                dout3 = tbl[k];
                @(negedge clk);
                chk("s3_read_strobe", 128'(aip_read3), (k < 3) ? 128'd1 : 128'd0);
                if (k == 0)
                    chk("s3_cfg", 128'(aip_config3), 128'd7);
                if (k == 3) begin
                    chk("s3_rsp_valid", 128'(rsp_valid3), 128'(2'b01));
                    chk("s3_rsp_data", 128'(rsp_data3), 128'h333);
                end
            end
        end

        chk("slave_queue_empty", 128'(slv_q.size()), 128'd0);
        chk("rsp_queue_empty", 128'(rsp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
